// File: rtl/cic_pkg.sv
// Shared CIC filter defaults and helpers used by the comb decimator.
package cic_pkg;

    // Default filter geometry (overridable per instance).
    localparam int CIC_WIDTH      = 16;
    localparam int CIC_STAGES     = 3;
    localparam int CIC_DIFF_DELAY = 1;
    localparam int CIC_RATE       = 8;

    // Sample type at the default data width.
    typedef logic [CIC_WIDTH-1:0] sample_t;

    // Width of the decimation phase counter for a given rate.
    function automatic int phase_width(input int rate);
        return $clog2(rate);
    endfunction

endpackage

// File: rtl/cic_comb_decimator_vc.sv
// Assertion checker for the comb decimator, bound into every instance when SVA_ENABLE
// is defined, in the same way as the integrator checker.
`ifdef SVA_ENABLE
module cic_comb_decimator_vc
    import cic_pkg::*;
#(
    parameter int STAGES = CIC_STAGES,
    parameter int RATE   = CIC_RATE
) (
    input logic                         clk,
    input logic                         rstn,
    input logic                         clear,
    input logic                         x_valid,
    input logic                         y_valid,
    input logic                         w_accept,
    input logic [phase_width(RATE)-1:0] phase
);

    // Phase never leaves the frame.
    a_phase_range : assert property (@(posedge clk) disable iff (!rstn)
        int'(phase) < RATE);

    // Without a valid input the frame position is frozen.
    a_phase_hold : assert property (@(posedge clk) disable iff (!rstn)
        (!x_valid && !clear) |=> $stable(phase));

    // Output strobe is a single-cycle pulse.
    a_strobe_width : assert property (@(posedge clk) disable iff (!rstn)
        y_valid |=> !y_valid);

    // Every accepted sample reaches the output exactly STAGES cycles later.
    a_latency : assert property (@(posedge clk) disable iff (!rstn || clear)
        w_accept |-> ##STAGES y_valid);

    // Clear flushes the frame and any sample in flight.
    a_clear_flush : assert property (@(posedge clk) disable iff (!rstn)
        clear |=> (phase == '0) && !y_valid);

endmodule

bind cic_comb_decimator cic_comb_decimator_vc #(
    .STAGES (STAGES),
    .RATE   (RATE)
) u_vc (.*);
`endif

// File: rtl/comb_stage.sv
// One CIC comb (differentiator) stage: y(n) = x(n) - x(n-DIFF_DELAY), modulo 2^WIDTH.
// Runs only on its enable; valid_out is the enable delayed by one clock.
module comb_stage #(
    parameter int WIDTH      = 16,
    parameter int DIFF_DELAY = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             valid_out
);

    // r_dly[0] holds x(n-1), r_dly[DIFF_DELAY-1] holds x(n-DIFF_DELAY).
    logic [WIDTH-1:0] r_dly [DIFF_DELAY];
    logic [WIDTH-1:0] r_y;
    logic             r_valid;

    // Differentiator and its delay line advance together on each enabled sample.
    // NOTE: sequential state uses non-blocking assignments so the subtraction and the
    // shift both see the pre-edge contents of the delay line.
    // NOTE: the delay line is cleared on reset like any other register; the warm-up
    // transient of the filter is defined as starting from an all-zero history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_y <= '0;
            for (int i = 0; i < DIFF_DELAY; i++) begin
                r_dly[i] <= '0;
            end
        end else if (clear) begin
            r_y <= '0;
            for (int i = 0; i < DIFF_DELAY; i++) begin
                r_dly[i] <= '0;
            end
        end else if (en) begin
            r_y      <= x - r_dly[DIFF_DELAY-1];
            r_dly[0] <= x;
            for (int i = 1; i < DIFF_DELAY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Valid bit follows the enable by one cycle; clear drops any sample in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
        end else if (clear) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= en;
        end
    end

    assign y         = r_y;
    assign valid_out = r_valid;

endmodule

// File: rtl/cic_comb_decimator.sv
// CIC back end: decimates the integrator output by RATE and runs STAGES comb stages
// at the decimated rate. One output strobe per RATE valid inputs, STAGES cycles after
// the accepted sample. Arithmetic wraps modulo 2^WIDTH so integrator overflow cancels.
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int WIDTH      = CIC_WIDTH,
    parameter int STAGES     = CIC_STAGES,
    parameter int DIFF_DELAY = CIC_DIFF_DELAY,
    parameter int RATE       = CIC_RATE
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           clear,
    input  logic [WIDTH-1:0]               x,
    input  logic                           x_valid,
    output logic [WIDTH-1:0]               y,
    output logic                           y_valid,
    output logic [phase_width(RATE)-1:0]   phase
);

    localparam int            PW         = phase_width(RATE);
    localparam logic [PW-1:0] PHASE_LAST = PW'(RATE - 1);

    logic [PW-1:0]                r_phase;
    logic                         w_accept;
    logic [STAGES:0][WIDTH-1:0]   w_data;
    logic [STAGES:0]              w_en;

    // Frame position: counts valid inputs only, so gaps in x_valid never shift the frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase <= '0;
        end else if (clear) begin
            r_phase <= '0;
        end else if (x_valid) begin
            r_phase <= (r_phase == PHASE_LAST) ? '0 : r_phase + PW'(1);
        end
    end

    // Keep only the last sample of each frame; clear wins over a valid input.
    assign w_accept = x_valid && !clear && (r_phase == PHASE_LAST);

    assign w_data[0] = x;
    assign w_en[0]   = w_accept;

    // Comb cascade: each stage is enabled by the valid strobe of the stage before it,
    // so the chain of valid_out bits forms the valid pipeline.
    for (genvar k = 0; k < STAGES; k++) begin : g_comb
        comb_stage #(
            .WIDTH      (WIDTH),
            .DIFF_DELAY (DIFF_DELAY)
        ) u_comb (
            .clk       (clk),
            .rstn      (rstn),
            .clear     (clear),
            .en        (w_en[k]),
            .x         (w_data[k]),
            .y         (w_data[k+1]),
            .valid_out (w_en[k+1])
        );
    end

    assign y       = w_data[STAGES];
    assign y_valid = w_en[STAGES];
    assign phase   = r_phase;

endmodule

// File: tb/tb_cic_comb_decimator.sv
// Self-checking bench for cic_comb_decimator. Three instances share one stimulus:
//   a: STAGES=3, DIFF_DELAY=1   b: STAGES=1, DIFF_DELAY=1   c: STAGES=3, DIFF_DELAY=2
// all with WIDTH=16, RATE=4. A reference phase counter decides when a sample is
// accepted; the expected output and its due cycle are queued then and popped when the
// instance under test raises y_valid.
module tb_cic_comb_decimator;

    localparam int RATE_T = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clear = 1'b0;
    logic        x_valid = 1'b0;
    logic [15:0] x = '0;

    logic [15:0] y_a, y_b, y_c;
    logic        v_a, v_b, v_c;
    logic [1:0]  ph_a, ph_b, ph_c;

    logic [15:0] src[$];     // expected outputs, in order, for the running test
    logic [15:0] sb_val[$];  // scoreboard: expected value per accepted sample
    int          sb_cyc[$];  // scoreboard: cycle the output is due
    int          cyc;
    int          m_phase;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    cic_comb_decimator #(.WIDTH(16), .STAGES(3), .DIFF_DELAY(1), .RATE(RATE_T)) u_dut_a (
        .clk(clk), .rstn(rstn), .clear(clear), .x(x), .x_valid(x_valid),
        .y(y_a), .y_valid(v_a), .phase(ph_a));

    cic_comb_decimator #(.WIDTH(16), .STAGES(1), .DIFF_DELAY(1), .RATE(RATE_T)) u_dut_b (
        .clk(clk), .rstn(rstn), .clear(clear), .x(x), .x_valid(x_valid),
        .y(y_b), .y_valid(v_b), .phase(ph_b));

    cic_comb_decimator #(.WIDTH(16), .STAGES(3), .DIFF_DELAY(2), .RATE(RATE_T)) u_dut_c (
        .clk(clk), .rstn(rstn), .clear(clear), .x(x), .x_valid(x_valid),
        .y(y_c), .y_valid(v_c), .phase(ph_c));

    // Apply reset for two cycles and restart the reference model at cycle 0.
    task automatic do_reset();
        rstn = 1'b0; clear = 1'b0; x = '0; x_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        m_phase = 0; cyc = 0;
        sb_val.delete(); sb_cyc.delete(); src.delete();
    endtask

    // Present one cycle of input; on an accept, queue the next expected output due
    // lat cycles later. Returns at the following falling edge with cyc = observed cycle.
    task automatic drive(input logic [15:0] xv, input logic v, input logic clr, input int lat);
        if (!clr && v && m_phase == RATE_T - 1) begin
            sb_val.push_back((src.size() > 0) ? src.pop_front() : 16'h0000);
            sb_cyc.push_back(cyc + lat);
        end
        x = xv; x_valid = v; clear = clr;
        @(negedge clk);
        if (clr) begin
            m_phase = 0;
            sb_val.delete(); sb_cyc.delete();
        end else if (v) begin
            m_phase = (m_phase + 1) % RATE_T;
        end
        cyc++;
    endtask

    task automatic test_reset();
        rstn = 1'b0; clear = 1'b0; x = 16'h1234; x_valid = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({y_a, v_a, ph_a} !== 19'h0) begin
            n_err++; $display("FAIL reset_a: y=%h y_valid=%b phase=%0d, expected all zero", y_a, v_a, ph_a);
        end
        n_cmp++;
        if ({y_b, v_b, ph_b} !== 19'h0) begin
            n_err++; $display("FAIL reset_b: y=%h y_valid=%b phase=%0d, expected all zero", y_b, v_b, ph_b);
        end
        n_cmp++;
        if ({y_c, v_c, ph_c} !== 19'h0) begin
            n_err++; $display("FAIL reset_c: y=%h y_valid=%b phase=%0d, expected all zero", y_c, v_c, ph_c);
        end
        x_valid = 1'b0;
    endtask

    // Constant 5: outputs 5, -10, 5, then 0; first strobe in cycle 6; y holds between strobes.
    task automatic test_constant();
        logic [15:0] ev;
        logic [15:0] last = '0;
        int          ec;
        do_reset();
        src = '{16'h0005, 16'hFFF6, 16'h0005};
        for (int i = 0; i < 44; i++) begin
            drive(16'h0005, i < 40, 1'b0, 3);
            if (v_a) begin
                n_cmp++;
                if (sb_val.size() == 0) begin
                    n_err++; $display("FAIL const_y: cycle %0d y_valid with y=%h, expected no output", cyc, y_a);
                end else begin
                    ev = sb_val.pop_front(); ec = sb_cyc.pop_front(); last = ev;
                    if (y_a !== ev || cyc != ec) begin
                        n_err++; $display("FAIL const_y: cycle %0d y=%h, expected %h in cycle %0d", cyc, y_a, ev, ec);
                    end
                end
            end else begin
                n_cmp++;
                if (y_a !== last) begin
                    n_err++; $display("FAIL const_hold: cycle %0d y=%h, expected held %h", cyc, y_a, last);
                end
            end
            n_cmp++;
            if (ph_a !== 2'(m_phase)) begin
                n_err++; $display("FAIL const_phase: cycle %0d phase=%0d, expected %0d", cyc, ph_a, m_phase);
            end
        end
        n_cmp++;
        if (sb_val.size() != 0) begin
            n_err++; $display("FAIL const_missing: %0d outputs never appeared, expected 0", sb_val.size());
        end
    endtask

    // Ramp x=n: accepts 3,7,11,... give 3, -2, -1, then 0.
    task automatic test_ramp();
        logic [15:0] ev;
        int          ec;
        do_reset();
        src = '{16'h0003, 16'hFFFE, 16'hFFFF};
        for (int i = 0; i < 44; i++) begin
            drive(16'(i), i < 40, 1'b0, 3);
            if (v_a) begin
                n_cmp++;
                if (sb_val.size() == 0) begin
                    n_err++; $display("FAIL ramp_y: cycle %0d y_valid with y=%h, expected no output", cyc, y_a);
                end else begin
                    ev = sb_val.pop_front(); ec = sb_cyc.pop_front();
                    if (y_a !== ev || cyc != ec) begin
                        n_err++; $display("FAIL ramp_y: cycle %0d y=%h, expected %h in cycle %0d", cyc, y_a, ev, ec);
                    end
                end
            end
        end
        n_cmp++;
        if (sb_val.size() != 0) begin
            n_err++; $display("FAIL ramp_missing: %0d outputs never appeared, expected 0", sb_val.size());
        end
    endtask

    // Single stage, accepted 0xFFFE then 0x0002: modular difference gives 0xFFFE, 0x0004.
    task automatic test_wrap();
        logic [15:0] ev;
        int          ec;
        do_reset();
        src = '{16'hFFFE, 16'h0004};
        for (int i = 0; i < 10; i++) begin
            drive((i < 4) ? 16'hFFFE : 16'h0002, i < 8, 1'b0, 1);
            if (v_b) begin
                n_cmp++;
                if (sb_val.size() == 0) begin
                    n_err++; $display("FAIL wrap_y: cycle %0d y_valid with y=%h, expected no output", cyc, y_b);
                end else begin
                    ev = sb_val.pop_front(); ec = sb_cyc.pop_front();
                    if (y_b !== ev || cyc != ec) begin
                        n_err++; $display("FAIL wrap_y: cycle %0d y=%h, expected %h in cycle %0d", cyc, y_b, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (ph_b !== 2'(m_phase)) begin
                n_err++; $display("FAIL wrap_phase: cycle %0d phase=%0d, expected %0d", cyc, ph_b, m_phase);
            end
        end
        n_cmp++;
        if (sb_val.size() != 0) begin
            n_err++; $display("FAIL wrap_missing: %0d outputs never appeared, expected 0", sb_val.size());
        end
    endtask

    // x_valid alternating over 16 cycles: 8 valid samples, exactly two strobes.
    task automatic test_gapped();
        logic [15:0] ev;
        int          ec;
        int          pulses = 0;
        do_reset();
        src = '{16'h0005, 16'hFFF6};
        for (int i = 0; i < 20; i++) begin
            drive(16'h0005, (i < 16) && (i % 2 == 0), 1'b0, 3);
            if (v_a) begin
                pulses++;
                n_cmp++;
                if (sb_val.size() == 0) begin
                    n_err++; $display("FAIL gap_y: cycle %0d y_valid with y=%h, expected no output", cyc, y_a);
                end else begin
                    ev = sb_val.pop_front(); ec = sb_cyc.pop_front();
                    if (y_a !== ev || cyc != ec) begin
                        n_err++; $display("FAIL gap_y: cycle %0d y=%h, expected %h in cycle %0d", cyc, y_a, ev, ec);
                    end
                end
            end
            n_cmp++;
            if (ph_a !== 2'(m_phase)) begin
                n_err++; $display("FAIL gap_phase: cycle %0d phase=%0d, expected %0d", cyc, ph_a, m_phase);
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_err++; $display("FAIL gap_pulses: saw %0d y_valid pulses, expected 2", pulses);
        end
    endtask

    // Clear with a sample in flight: it is dropped, phase restarts, sequence restarts.
    task automatic test_clear();
        logic [15:0] ev;
        int          ec;
        do_reset();
        src = '{16'h0005, 16'hFFF6, 16'h0005};
        for (int i = 0; i < 5; i++) begin
            drive(16'h0005, 1'b1, 1'b0, 3);
            n_cmp++;
            if (v_a !== 1'b0) begin
                n_err++; $display("FAIL clear_early: cycle %0d y_valid=%b, expected 0", cyc, v_a);
            end
        end
        drive(16'h0005, 1'b1, 1'b1, 3);
        n_cmp++;
        if (ph_a !== 2'd0 || v_a !== 1'b0) begin
            n_err++; $display("FAIL clear_state: phase=%0d y_valid=%b, expected phase 0 y_valid 0", ph_a, v_a);
        end
        src = '{16'h0005, 16'hFFF6, 16'h0005};
        for (int i = 0; i < 44; i++) begin
            drive(16'h0005, i < 40, 1'b0, 3);
            if (v_a) begin
                n_cmp++;
                if (sb_val.size() == 0) begin
                    n_err++; $display("FAIL clear_y: cycle %0d y_valid with y=%h, expected no output", cyc, y_a);
                end else begin
                    ev = sb_val.pop_front(); ec = sb_cyc.pop_front();
                    if (y_a !== ev || cyc != ec) begin
                        n_err++; $display("FAIL clear_y: cycle %0d y=%h, expected %h in cycle %0d", cyc, y_a, ev, ec);
                    end
                end
            end
        end
        n_cmp++;
        if (sb_val.size() != 0) begin
            n_err++; $display("FAIL clear_missing: %0d outputs never appeared, expected 0", sb_val.size());
        end
    endtask

    // Asynchronous reset between an accept and its strobe: outputs drop at once.
    task automatic test_async_reset();
        logic [15:0] ev;
        int          ec;
        do_reset();
        src = '{16'h0005, 16'hFFF6, 16'h0005};
        for (int i = 0; i < 9; i++) begin
            drive(16'h0005, 1'b1, 1'b0, 3);
            if (v_a) begin
                n_cmp++;
                if (sb_val.size() == 0) begin
                    n_err++; $display("FAIL async_y: cycle %0d y_valid with y=%h, expected no output", cyc, y_a);
                end else begin
                    ev = sb_val.pop_front(); ec = sb_cyc.pop_front();
                    if (y_a !== ev || cyc != ec) begin
                        n_err++; $display("FAIL async_y: cycle %0d y=%h, expected %h in cycle %0d", cyc, y_a, ev, ec);
                    end
                end
            end
        end
        // Sample accepted in cycle 7 is in flight; y still holds 5 from cycle 6.
        #2 rstn = 1'b0;
        #1;
        n_cmp++;
        if (y_a !== 16'h0 || v_a !== 1'b0 || ph_a !== 2'd0) begin
            n_err++; $display("FAIL async_state: y=%h y_valid=%b phase=%0d, expected 0/0/0", y_a, v_a, ph_a);
        end
        @(negedge clk);
        rstn = 1'b1;
        m_phase = 0;
        sb_val.delete(); sb_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            drive(16'h0005, 1'b0, 1'b0, 3);
            n_cmp++;
            if (v_a !== 1'b0) begin
                n_err++; $display("FAIL async_stale: cycle %0d y_valid=%b, expected 0", cyc, v_a);
            end
        end
    endtask

    // DIFF_DELAY=2 with constant 5: 5, 5, -10, -10, 5, 5, then 0.
    task automatic test_diff_delay2();
        logic [15:0] ev;
        int          ec;
        do_reset();
        src = '{16'h0005, 16'h0005, 16'hFFF6, 16'hFFF6, 16'h0005, 16'h0005};
        for (int i = 0; i < 44; i++) begin
            drive(16'h0005, i < 40, 1'b0, 3);
            if (v_c) begin
                n_cmp++;
                if (sb_val.size() == 0) begin
                    n_err++; $display("FAIL m2_y: cycle %0d y_valid with y=%h, expected no output", cyc, y_c);
                end else begin
                    ev = sb_val.pop_front(); ec = sb_cyc.pop_front();
                    if (y_c !== ev || cyc != ec) begin
                        n_err++; $display("FAIL m2_y: cycle %0d y=%h, expected %h in cycle %0d", cyc, y_c, ev, ec);
                    end
                end
            end
        end
        n_cmp++;
        if (sb_val.size() != 0) begin
            n_err++; $display("FAIL m2_missing: %0d outputs never appeared, expected 0", sb_val.size());
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_ramp();
        test_wrap();
        test_gapped();
        test_clear();
        test_async_reset();
        test_diff_delay2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
